whack_auto_player: RTL and testbench

On-chip automatic player for the whack-a-mole game, used for demo and board self-test. It sits on the opposite side of the game's play interface: it watches the mole lamp vector the game drives and presses the matching button after a programmable reaction delay. Its button outputs are muxed onto the game's button inputs by the top level.

---
 rtl/whack_auto_player.sv | 129 ++++++++++++
 tb/tb_whack_auto_player.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/whack_auto_player.sv
// Automatic whack-a-mole player: watches the mole lamps and presses the matching button after a tick-based delay.
// Optional build macro AUTOPLAYER_JITTER_EN adds LFSR jitter (0..7 ticks) to the captured reaction delay.
module whack_auto_player #(
  parameter int N_MOLES         = 8,
  parameter int TICK_DIV        = 1000,
  parameter int PRESS_TICKS     = 20,
  parameter int RELEASE_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_MOLES-1:0] mole_leds,
  input  logic [7:0]         react_dly,
  output logic [N_MOLES-1:0] btn,
  output logic               busy,
  output logic [7:0]         press_count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [7:0]    PRESS_LAST = 8'(PRESS_TICKS - 1);
  localparam logic [7:0]    REL_LAST   = 8'(RELEASE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REACT, PRESS, RELEASE} state_t;

  state_t             state, state_n;
  logic [PW-1:0]      pre_cnt;
  logic               tick;
  logic [7:0]         tcnt, tcnt_n;
  logic [7:0]         dly, dly_n;
  logic [7:0]         count_n;
  logic [7:0]         cap_dly;
  logic [N_MOLES-1:0] target, target_n;
  logic [N_MOLES-1:0] btn_n;
  logic               mole_on;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

`ifdef AUTOPLAYER_JITTER_EN
  logic [7:0] lfsr;
  logic [8:0] jit_sum;

  // Fibonacci form of x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign jit_sum = {1'b0, react_dly} + {6'd0, lfsr[2:0]};
  assign cap_dly = jit_sum[8] ? 8'hFF : jit_sum[7:0];
`else
  assign cap_dly = react_dly;
`endif

  // target is held as a one-hot mask, so it doubles as the button pattern
  assign mole_on = |(mole_leds & target);
  assign busy    = (state != IDLE);

  always_comb begin
    state_n  = state;
    tcnt_n   = tick ? tcnt + 8'd1 : tcnt;
    dly_n    = dly;
    target_n = target;
    count_n  = press_count;
    btn_n    = '0;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if ($onehot(mole_leds)) begin
            target_n = mole_leds;
            dly_n    = cap_dly;
            tcnt_n   = '0;
            state_n  = REACT;
          end
        end
        REACT: begin
          // leave on the tick that completes the delay, so a partial first tick counts
          if (!mole_on) begin
            state_n = IDLE;
          end else if (dly == 8'd0 || (tick && tcnt == dly - 8'd1)) begin
            state_n = PRESS;
            count_n = press_count + 8'd1;
            tcnt_n  = '0;
            btn_n   = target;
          end
        end
        PRESS: begin
          if (tick && tcnt == PRESS_LAST) begin
            state_n = RELEASE;
            tcnt_n  = '0;
          end else begin
            btn_n = target;
          end
        end
        RELEASE: begin
          if (!mole_on || (tick && tcnt == REL_LAST)) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      dly         <= '0;
      target      <= '0;
      press_count <= '0;
      btn         <= '0;
    end else begin
      state       <= state_n;
      tcnt        <= tcnt_n;
      dly         <= dly_n;
      target      <= target_n;
      press_count <= count_n;
      btn         <= btn_n;
    end
  end

endmodule

// File: tb/tb_whack_auto_player.sv
// Self-checking bench for whack_auto_player; timing is predicted from tick positions counted since reset release.
module tb_whack_auto_player;

  localparam int N  = 8;
  localparam int D  = 4;
  localparam int PT = 3;
  localparam int RT = 10;
`ifdef AUTOPLAYER_JITTER_EN
  localparam int JMAX = 7;
`else
  localparam int JMAX = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [N-1:0] mole_leds = '0;
  logic [7:0]   react_dly = '0;
  logic [N-1:0] btn;
  logic         busy;
  logic [7:0]   press_count;

  int         total = 0;
  int         bad = 0;
  int         cyc;
  logic [7:0] exp_count = 8'd0;

  whack_auto_player #(
    .N_MOLES(N), .TICK_DIV(D), .PRESS_TICKS(PT), .RELEASE_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mole_leds(mole_leds),
    .react_dly(react_dly), .btn(btn), .busy(busy), .press_count(press_count)
  );

  always #5 clk = ~clk;

  // Edge k after reset release is a tick edge when k is a multiple of D.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int nth_tick(input int a, input int n);
    return (a / D + n) * D;
  endfunction

  function automatic int ticks_between(input int a, input int b);
    return b / D - a / D;
  endfunction

  function automatic bit timing_ok(input int c, input int p, input int d);
    int hi;
    int tk;
    hi = (d + JMAX > 255) ? 255 : d + JMAX;
    tk = ticks_between(c, p);
    if (d == 0 && p == c + 1) return 1'b1;
    if (d == 0 && JMAX == 0) return 1'b0;
    return (p % D == 0) && tk >= d && tk <= hi && tk >= 1;
  endfunction

  task automatic wait_btn(input bit want_on, input int budget, output int edge_at, output bit ok);
    ok = 1'b0;
    edge_at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((btn != '0) == want_on) begin
        ok = 1'b1;
        edge_at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output int edge_at, output bit ok);
    ok = 1'b0;
    edge_at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        edge_at = cyc;
        break;
      end
    end
  endtask

  task automatic start_capture(input int t, input logic [7:0] d, output int c);
    react_dly = d;
    mole_leds = N'(1) << t;
    c = cyc + 1;
  endtask

  task automatic test_reset();
    bit seen;
    @(negedge clk);
    total++; if (btn !== '0) begin bad++; $display("FAIL reset_btn: got=%h want=0", btn); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
    total++; if (press_count !== 8'd0) begin bad++; $display("FAIL reset_count: got=%0d want=0", press_count); end
    rst = 1'b0;
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || btn !== '0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL idle_quiet: activity=1 want=0"); end
  endtask

  task automatic test_basic_hit(input int t, input logic [7:0] d);
    int c, p, r;
    bit ok;
    start_capture(t, d, c);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL capture_busy: got=%b want=1", busy); end
    wait_btn(1'b1, 1300, p, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL press_timeout: btn stayed 0 want press");
      mole_leds = '0;
      repeat (60) @(negedge clk);
      return;
    end
    if (!timing_ok(c, p, d)) begin bad++; $display("FAIL press_latency: capture=%0d press=%0d dly=%0d", c, p, d); end
    total++; if (btn !== N'(1) << t) begin bad++; $display("FAIL press_btn: got=%h want=%h", btn, N'(1) << t); end
    exp_count = exp_count + 8'd1;
    total++; if (press_count !== exp_count) begin bad++; $display("FAIL press_count: got=%0d want=%0d", press_count, exp_count); end
    wait_btn(1'b0, 200, r, ok);
    total++; if (!ok || r != nth_tick(p, PT)) begin bad++; $display("FAIL press_width: release=%0d want=%0d", r, nth_tick(p, PT)); end
    mole_leds = '0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy: got=%b want=0", busy); end
  endtask

  task automatic test_miss();
    int c;
    bit seen;
    start_capture($urandom_range(0, N - 1), 8'd20, c);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (btn !== '0) seen = 1'b1;
    end
    mole_leds = '0;
    repeat (2) begin
      @(negedge clk);
      if (btn !== '0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL miss_btn: pressed=1 want=0"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL miss_busy: got=%b want=0", busy); end
    total++; if (press_count !== exp_count) begin bad++; $display("FAIL miss_count: got=%0d want=%0d", press_count, exp_count); end
  endtask

  task automatic test_invalid();
    logic [N-1:0] v;
    bit seen;
    seen = 1'b0;
    mole_leds = 8'h11;
    for (int i = 0; i < 200; i++) begin
      if (i >= 40 && i % 20 == 0) begin
        v = N'($urandom);
        while ($countones(v) < 2) v = N'($urandom);
        mole_leds = (i == 180) ? '0 : v;
      end
      @(negedge clk);
      if (busy !== 1'b0 || btn !== '0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL invalid_lamps: activity=1 want=0"); end
    mole_leds = '0;
  endtask

  task automatic test_enable_drop();
    int c, p;
    bit ok;
    start_capture($urandom_range(0, N - 1), 8'd1, c);
    wait_btn(1'b1, 100, p, ok);
    total++; if (!ok) begin bad++; $display("FAIL en_press_timeout: btn stayed 0 want press"); end
    if (ok) exp_count = exp_count + 8'd1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    total++; if (btn !== '0) begin bad++; $display("FAIL en_drop_btn: got=%h want=0", btn); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_drop_busy: got=%b want=0", busy); end
    total++; if (press_count !== exp_count) begin bad++; $display("FAIL en_drop_count: got=%0d want=%0d", press_count, exp_count); end
    mole_leds = '0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [7:0] saved;
    int c, p, i_at;
    bit ok;
    saved = exp_count;
    for (int n = 0; n < 256; n++) begin
      start_capture($urandom_range(0, N - 1), 8'($urandom_range(0, 1)), c);
      wait_btn(1'b1, 50, p, ok);
      if (!ok) begin
        total++; bad++; $display("FAIL wrap_press_timeout: iteration=%0d", n);
        break;
      end
      exp_count = exp_count + 8'd1;
      mole_leds = '0;
      wait_idle(60, i_at, ok);
      if (!ok) begin
        total++; bad++; $display("FAIL wrap_idle_timeout: iteration=%0d", n);
        break;
      end
    end
    mole_leds = '0;
    @(negedge clk);
    total++; if (press_count !== saved) begin bad++; $display("FAIL wrap_count: got=%0d want=%0d", press_count, saved); end
  endtask

  task automatic test_stuck(input logic [7:0] d, input int reps);
    int c, p, r, i_at, tk, tmin, tmax;
    bit ok;
    tmin = 1000;
    tmax = -1;
    start_capture(0, d, c);
    for (int n = 0; n < reps; n++) begin
      wait_btn(1'b1, 1300, p, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL stuck_press_timeout: iteration=%0d", n); break; end
      if (!timing_ok(c, p, d)) begin bad++; $display("FAIL stuck_latency: capture=%0d press=%0d dly=%0d", c, p, d); end
      tk = ticks_between(c, p);
      if (tk < tmin) tmin = tk;
      if (tk > tmax) tmax = tk;
      exp_count = exp_count + 8'd1;
      wait_btn(1'b0, 100, r, ok);
      total++; if (!ok || r != nth_tick(p, PT)) begin bad++; $display("FAIL stuck_width: release=%0d want=%0d", r, nth_tick(p, PT)); end
      wait_idle(100, i_at, ok);
      total++; if (!ok || i_at != nth_tick(r, RT)) begin bad++; $display("FAIL release_timeout: idle=%0d want=%0d", i_at, nth_tick(r, RT)); end
      c = i_at + 1;
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL recapture: busy=%b want=1", busy); end
    end
`ifdef AUTOPLAYER_JITTER_EN
    if (reps >= 8 && d < 8'd248) begin
      total++; if (tmax <= tmin) begin bad++; $display("FAIL jitter_spread: min=%0d max=%0d want differing", tmin, tmax); end
    end
`endif
    mole_leds = '0;
    wait_idle(200, i_at, ok);
    total++; if (!ok || press_count !== exp_count) begin bad++; $display("FAIL stuck_count: got=%0d want=%0d", press_count, exp_count); end
  endtask

  task automatic test_async_reset();
    int c, p;
    bit ok;
    start_capture($urandom_range(0, N - 1), 8'd0, c);
    wait_btn(1'b1, 50, p, ok);
    total++; if (!ok) begin bad++; $display("FAIL areset_press_timeout: btn stayed 0 want press"); end
    #2 rst = 1'b1;
    #1;
    total++; if (btn !== '0) begin bad++; $display("FAIL areset_btn: got=%h want=0", btn); end
    total++; if (busy !== 1'b0 || press_count !== 8'd0) begin bad++; $display("FAIL areset_state: busy=%b count=%0d want 0/0", busy, press_count); end
    mole_leds = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 8'd0;
  endtask

  initial begin
    test_reset();
    test_basic_hit(4, 8'd2);
    for (int k = 0; k < 6; k++) test_basic_hit($urandom_range(0, N - 1), 8'($urandom_range(0, 5)));
    test_miss();
    test_invalid();
    test_enable_drop();
    test_wrap();
    test_stuck(8'($urandom_range(1, 3)), 8);
    test_stuck(8'd255, 1);
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
